// File: rtl/morse_symbol_tx.sv
// -----------------------------------------------------------------------------
// morse_symbol_tx
//
// Plays one Morse letter (up to MAX_LEN dots/dashes) on the game LED, timed by
// the shared 100 ms tick pulse. The game controller presents the letter code
// and pulses start. The block frames the letter with busy and ends it with a
// one-clock done pulse after the trailing gap.
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   tick      one-clk-wide 100 ms timebase pulse
//   start     request to play the letter on sym_len/sym_bits
//   sym_len   number of elements (0..7, clamped to MAX_LEN)
//   sym_bits  element pattern, 1 = dash, 0 = dot, bit sym_len-1 sent first
//   busy      high while a letter is in progress
//   done      one-clk pulse when a letter (including tail gap) completes
//   led_out   LED drive, high = mark
//   abort     (only with MORSE_SYMBOL_TX_ABORT_EN) drops the current letter
//
// Optional feature macro: MORSE_SYMBOL_TX_ABORT_EN adds the abort input.
// -----------------------------------------------------------------------------
module morse_symbol_tx #(
    parameter int DOT_TICKS  = 2,
    parameter int DASH_TICKS = 6,
    parameter int GAP_TICKS  = 2,
    parameter int TAIL_TICKS = 6,
    parameter int MAX_LEN    = 5
) (
`ifdef MORSE_SYMBOL_TX_ABORT_EN
    input  logic               abort,
`endif
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic [2:0]         sym_len,
    input  logic [MAX_LEN-1:0] sym_bits,
    output logic               busy,
    output logic               done,
    output logic               led_out
);

    localparam int MAX_AB = (DOT_TICKS > DASH_TICKS) ? DOT_TICKS : DASH_TICKS;
    localparam int MAX_CD = (GAP_TICKS > TAIL_TICKS) ? GAP_TICKS : TAIL_TICKS;
    localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_T) + 1;
    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // Compare values are target-1: the tick that reaches the target is the
    // one seen while the counter still holds target-1.
    localparam logic [CNT_W-1:0] DOT_M1  = CNT_W'(DOT_TICKS - 1);
    localparam logic [CNT_W-1:0] DASH_M1 = CNT_W'(DASH_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] TAIL_M1 = CNT_W'(TAIL_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MARK = 3'd1,
        GAP  = 3'd2,
        TAIL = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [IDX_W-1:0]     idx_r, idx_s;
    logic [MAX_LEN-1:0]   bits_r, bits_s;
    // Set for a zero-length letter: FIN is then held one extra cycle with
    // busy high before done, so an empty letter still shows a busy cycle.
    logic                 empty_r, empty_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic                 led_r, led_s;
    logic [2:0]           len_eff_s;
    logic [CNT_W-1:0]     tgt_s;
    logic                 hit_s;
    logic                 abort_s;

`ifdef MORSE_SYMBOL_TX_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Next-state, counter, index and letter-capture logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        bits_s  = bits_r;
        empty_s = empty_r;

        if (int'(sym_len) > MAX_LEN) begin
            len_eff_s = 3'(MAX_LEN);
        end else begin
            len_eff_s = sym_len;
        end

        case (state_r)
            MARK:    tgt_s = bits_r[idx_r] ? DASH_M1 : DOT_M1;
            GAP:     tgt_s = GAP_M1;
            TAIL:    tgt_s = TAIL_M1;
            default: tgt_s = {CNT_W{1'b0}};
        endcase
        hit_s = tick && (cnt_r == tgt_s);

        case (state_r)
            IDLE: begin
                if (start) begin
                    bits_s = sym_bits;
                    cnt_s  = {CNT_W{1'b0}};
                    if (len_eff_s == 3'd0) begin
                        state_s = FIN;
                        empty_s = 1'b1;
                    end else begin
                        state_s = MARK;
                        empty_s = 1'b0;
                        idx_s   = IDX_W'(len_eff_s - 3'd1);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MARK: begin
                if (hit_s) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = (idx_r != {IDX_W{1'b0}}) ? GAP : TAIL;
                end else if (tick) begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_s = cnt_r;
                end
            end
            GAP: begin
                if (hit_s) begin
                    cnt_s   = {CNT_W{1'b0}};
                    idx_s   = idx_r - {{(IDX_W-1){1'b0}}, 1'b1};
                    state_s = MARK;
                end else if (tick) begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_s = cnt_r;
                end
            end
            TAIL: begin
                if (hit_s) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = FIN;
                end else if (tick) begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_s = cnt_r;
                end
            end
            FIN: begin
                if (empty_r) begin
                    empty_s = 1'b0;
                    state_s = FIN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
                empty_s = 1'b0;
            end
        endcase

        // Abort only acts on a letter in progress; in IDLE start has priority.
        if (abort_s && busy_r) begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
            empty_s = 1'b0;
        end else begin
            state_s = state_s;
        end
    end

    // Output values for the next cycle, decoded from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        led_s  = (state_s == MARK);
        busy_s = (state_s == MARK) || (state_s == GAP) || (state_s == TAIL) ||
                 ((state_s == FIN) && empty_s);
        done_s = (state_s == FIN) && !empty_s;
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            bits_r  <= {MAX_LEN{1'b0}};
            empty_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            led_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            bits_r  <= bits_s;
            empty_r <= empty_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            led_r   <= led_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign led_out = led_r;

endmodule

// File: tb/tb_morse_symbol_tx.sv
// -----------------------------------------------------------------------------
// Self-checking bench for morse_symbol_tx. Expected LED segments (level and
// counted tick length) and a done marker (with total counted ticks) are pushed
// to a scoreboard when a letter is started; a monitor measures the LED and
// pops/compares each segment and the done pulse as they occur.
// -----------------------------------------------------------------------------
module tb_morse_symbol_tx;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       start;
    logic [2:0] sym_len;
    logic [4:0] sym_bits;
    logic       busy;
    logic       done;
    logic       led_out;
`ifdef MORSE_SYMBOL_TX_ABORT_EN
    logic       abort;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit is_done;
        bit lvl;      // segment level, or for a done marker: letter non-empty
        int ticks;    // segment length, or for a done marker: total ticks
    } exp_t;

    exp_t sb[$];

    morse_symbol_tx dut (
`ifdef MORSE_SYMBOL_TX_ABORT_EN
        .abort    (abort),
`endif
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .sym_len  (sym_len),
        .sym_bits (sym_bits),
        .busy     (busy),
        .done     (done),
        .led_out  (led_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick every 10 clocks, driven just after the rising edge.
    initial begin
        int phase;
        phase = 0;
        tick  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            phase = (phase == 9) ? 0 : phase + 1;
            tick  = (phase == 0);
        end
    end

    // Monitor: measures LED segments in counted ticks and checks done.
    initial begin
        bit   seg_open;
        bit   seg_lvl;
        int   seg_ticks;
        int   tot;
        bit   last_cnt;
        exp_t e;
        seg_open  = 1'b0;
        seg_lvl   = 1'b0;
        seg_ticks = 0;
        tot       = 0;
        last_cnt  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seg_open = 1'b0; seg_ticks = 0; tot = 0; last_cnt = 1'b0;
            end else begin
                if (led_out === 1'b1 && busy !== 1'b1) begin
                    total++; bad++;
                    $display("FAIL led_idle: led_out=%b busy=%b required led_out=0", led_out, busy);
                end
                if (seg_open && (done === 1'b1 || (busy === 1'b1 && led_out !== seg_lvl))) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL seg_unexpected: lvl=%b ticks=%0d required none", seg_lvl, seg_ticks);
                    end else begin
                        e = sb.pop_front();
                        if (e.is_done || e.lvl !== seg_lvl || e.ticks != seg_ticks) begin
                            bad++;
                            $display("FAIL segment: lvl=%b ticks=%0d required lvl=%b ticks=%0d done_marker=%b",
                                     seg_lvl, seg_ticks, e.lvl, e.ticks, e.is_done);
                        end
                    end
                end
                if (done === 1'b1) begin
                    total++;
                    if (busy !== 1'b0) begin
                        bad++;
                        $display("FAIL busy_with_done: busy=%b required 0", busy);
                    end
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL done_unexpected: done=1 required no done");
                    end else begin
                        e = sb.pop_front();
                        if (!e.is_done || tot != e.ticks || (e.lvl && !last_cnt)) begin
                            bad++;
                            $display("FAIL done_marker: ticks=%0d last_tick=%b required ticks=%0d marker=%b",
                                     tot, last_cnt, e.ticks, e.is_done);
                        end
                    end
                end
                if (done === 1'b1 || busy !== 1'b1) begin
                    seg_open = 1'b0; tot = 0;
                end else if (!seg_open) begin
                    if (led_out === 1'b1) begin
                        seg_open = 1'b1; seg_lvl = 1'b1; seg_ticks = 0;
                    end
                end else if (led_out !== seg_lvl) begin
                    seg_lvl = led_out; seg_ticks = 0;
                end
                last_cnt = 1'b0;
                if (busy === 1'b1 && seg_open && tick === 1'b1) begin
                    seg_ticks++; tot++; last_cnt = 1'b1;
                end
            end
        end
    end

    // Expected segments from the letter code: MSB-first elements, dot 2,
    // dash 6, inter-element gap 2, tail 6, then a done marker.
    task automatic push_letter(input logic [2:0] len, input logic [4:0] bits);
        int n;
        int tot;
        n   = (len > 3'd5) ? 5 : int'(len);
        tot = 0;
        for (int i = n - 1; i >= 0; i--) begin
            sb.push_back('{1'b0, 1'b1, bits[i] ? 6 : 2});
            tot += bits[i] ? 6 : 2;
            if (i > 0) begin
                sb.push_back('{1'b0, 1'b0, 2});
                tot += 2;
            end
        end
        if (n > 0) begin
            sb.push_back('{1'b0, 1'b0, 6});
            tot += 6;
        end
        sb.push_back('{1'b1, n > 0, tot});
    endtask

    task automatic pulse_start(input logic [2:0] len, input logic [4:0] bits);
        @(negedge clk);
        sym_len  = len;
        sym_bits = bits;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        sym_len  = 3'd3;
        sym_bits = 5'b10101;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || led_out !== 1'b0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b led=%b required 0 0 0", busy, done, led_out);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || led_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: busy=%b led=%b required 0 0", busy, led_out);
        end
    endtask

    task automatic test_letter_a;
        bit seen;
        push_letter(3'd2, 5'b00001);
        pulse_start(3'd2, 5'b00001);
        total++;
        if (led_out !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL a_latency: led=%b busy=%b required 1 1", led_out, busy);
        end
        wait_done(600, seen);
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL a_timeout: done=0 required done within budget");
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL a_after: busy=%b done=%b pending=%0d required 0 0 0", busy, done, sb.size());
        end
    endtask

    task automatic test_empty;
        push_letter(3'd0, 5'b11111);
        pulse_start(3'd0, 5'b11111);
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || led_out !== 1'b0) begin
            bad++;
            $display("FAIL empty_c1: busy=%b done=%b led=%b required 1 0 0", busy, done, led_out);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b1 || led_out !== 1'b0) begin
            bad++;
            $display("FAIL empty_c2: busy=%b done=%b led=%b required 0 1 0", busy, done, led_out);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL empty_c3: done=%b pending=%0d required 0 0", done, sb.size());
        end
    endtask

    task automatic test_clamp;
        bit seen;
        push_letter(3'd7, 5'b11111);
        pulse_start(3'd7, 5'b11111);
        wait_done(2000, seen);
        @(negedge clk);
        total++;
        if (!seen || sb.size() != 0) begin
            bad++;
            $display("FAIL clamp: seen=%b pending=%0d required 1 0", seen, sb.size());
        end
    endtask

    task automatic test_restart_ignored;
        bit seen;
        push_letter(3'd3, 5'b00101);
        pulse_start(3'd3, 5'b00101);
        repeat (40) @(negedge clk);
        pulse_start(3'd1, 5'b00000);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL restart_busy: busy=%b required 1", busy);
        end
        wait_done(1000, seen);
        repeat (80) @(negedge clk);
        total++;
        if (!seen || busy !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL restart: seen=%b busy=%b pending=%0d required 1 0 0", seen, busy, sb.size());
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        bit prev;
        int rises;
        bit got_done;
        push_letter(3'd2, 5'b00000);
        pulse_start(3'd2, 5'b00000);
        rises = 1;
        prev  = 1'b1;
        for (int n = 0; n < 400 && rises < 2; n++) begin
            @(negedge clk);
            if (led_out === 1'b1 && !prev) rises++;
            prev = (led_out === 1'b1);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (rises != 2 || led_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: rises=%0d led=%b busy=%b done=%b required 2 0 0 0", rises, led_out, busy, done);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        got_done = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (done === 1'b1) got_done = 1'b1;
        end
        total++;
        if (got_done) begin
            bad++;
            $display("FAIL rst_no_done: done=1 required 0");
        end
        push_letter(3'd2, 5'b00001);
        pulse_start(3'd2, 5'b00001);
        wait_done(600, seen);
        @(negedge clk);
        total++;
        if (!seen || sb.size() != 0) begin
            bad++;
            $display("FAIL rst_replay: seen=%b pending=%0d required 1 0", seen, sb.size());
        end
    endtask

`ifdef MORSE_SYMBOL_TX_ABORT_EN
    task automatic test_abort;
        bit fell;
        bit got_done;
        push_letter(3'd2, 5'b00000);
        pulse_start(3'd2, 5'b00000);
        fell = 1'b0;
        for (int n = 0; n < 400 && !fell; n++) begin
            @(negedge clk);
            if (led_out === 1'b0) fell = 1'b1;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (!fell || led_out !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort: fell=%b led=%b busy=%b required 1 0 0", fell, led_out, busy);
        end
        sb.delete();
        got_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1) got_done = 1'b1;
        end
        total++;
        if (got_done) begin
            bad++;
            $display("FAIL abort_no_done: done=1 required 0");
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        sym_len  = 3'd0;
        sym_bits = 5'b00000;
`ifdef MORSE_SYMBOL_TX_ABORT_EN
        abort    = 1'b0;
`endif
        test_reset();
        test_letter_a();
        test_empty();
        test_clamp();
        test_restart_ignored();
        test_reset_mid();
`ifdef MORSE_SYMBOL_TX_ABORT_EN
        test_abort();
`endif
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
